// File: rtl/tt_um_rescobar_alu_seq_if.sv
// Pin-level bus of the ALU sequencer tile: Tiny Tapeout dedicated and bidirectional pins.
// The master end drives the input pins and the slave end drives the output pins.
interface tt_um_rescobar_alu_seq_if;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output io_in, output uio_in, input io_out, input uio_out, input uio_oe);
  modport slave  (input io_in, input uio_in, output io_out, output uio_out, output uio_oe);
endinterface

// File: rtl/tt_um_rescobar_alu_seq.sv
// Sequenced operand loader/executor for the 4-bit ALU tile: captures A, then B and op,
// on strobe edges, executes once and holds a registered result with carry/zero/valid.
module tt_um_rescobar_alu_seq (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  tt_um_rescobar_alu_seq_if.slave   bus
);

  // One-hot encoding so the state register drives uio_out[3:0] directly.
  typedef enum logic [3:0] {
    S_LOAD_A = 4'b0001,
    S_LOAD_B = 4'b0010,
    S_EXEC   = 4'b0100,
    S_SHOW   = 4'b1000
  } state_t;

  state_t     r_state;
  logic [1:0] r_stb_sync;
  logic [1:0] r_clr_sync;
  logic       r_stb_d;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [1:0] r_op;
  logic [3:0] r_result;
  logic       r_carry;
  logic       r_zero;
  logic       r_valid;

  logic       w_stb_p;
  logic       w_clr_s;
  logic       w_busy;
  logic [4:0] w_alu;
  logic       w_unused;

  // Synchronizers run regardless of ena; the edge flop holds with the rest of the state,
  // so a strobe that rises and falls entirely while ena is low never makes a pulse.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stb_sync <= 2'b00;
      r_clr_sync <= 2'b00;
      r_stb_d    <= 1'b0;
    end else begin
      r_stb_sync <= {r_stb_sync[0], bus.io_in[6]};
      r_clr_sync <= {r_clr_sync[0], bus.io_in[7]};
      if (ena) r_stb_d <= r_stb_sync[1];
    end
  end

  assign w_stb_p = r_stb_sync[1] & ~r_stb_d;
  assign w_clr_s = r_clr_sync[1];

  // Five-bit arithmetic: bit 4 of the difference is the borrow (A < B).
  // NOTE: default assignment first so no path through the case leaves w_alu unassigned (no latch).
  always_comb begin
    w_alu = 5'd0;
    case (r_op)
      2'b00:   w_alu = {1'b0, r_a} + {1'b0, r_b};
      2'b01:   w_alu = {1'b0, r_a} - {1'b0, r_b};
      2'b10:   w_alu = {1'b0, r_a & r_b};
      default: w_alu = {1'b0, r_a | r_b};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_LOAD_A;
      r_a      <= 4'd0;
      r_b      <= 4'd0;
      r_op     <= 2'd0;
      r_result <= 4'd0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else if (w_clr_s) begin
      // Clear abandons the transaction but keeps the last result and flags visible.
      r_state <= S_LOAD_A;
      r_valid <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_LOAD_A: begin
          if (w_stb_p) begin
            r_a     <= bus.io_in[3:0];
            r_state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (w_stb_p) begin
            r_b     <= bus.io_in[3:0];
            r_op    <= bus.io_in[5:4];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= w_alu[3:0];
          r_carry  <= w_alu[4];
          r_zero   <= (w_alu[3:0] == 4'd0);
          r_valid  <= 1'b1;
          r_state  <= S_SHOW;
        end
        S_SHOW: begin
          if (w_stb_p) begin
            r_a     <= bus.io_in[3:0];
            r_valid <= 1'b0;
            r_state <= S_LOAD_B;
          end
        end
        default: r_state <= S_LOAD_A;
      endcase
    end
  end

  assign w_busy      = (r_state == S_LOAD_B) || (r_state == S_EXEC);
  assign bus.io_out  = {w_busy, r_valid, r_zero, r_carry, r_result};
  assign bus.uio_out = {4'h0, r_state};
  assign bus.uio_oe  = 8'h0F;

  // Bidirectional inputs are not used by this tile.
  assign w_unused = &{1'b0, bus.uio_in};

endmodule

// File: tb/tb_tt_um_rescobar_alu_seq.sv
// Directed self-checking bench for tt_um_rescobar_alu_seq: hand-computed pin values
// checked with immediate assertions after each step.
module tb_tt_um_rescobar_alu_seq;

  logic clk;
  logic rst_n;
  logic ena;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  tt_um_rescobar_alu_seq_if bus_if ();

  tt_um_rescobar_alu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full strobe transfer: rise, hold through capture, drop, then idle long enough
  // for the synchronizer and edge flop to settle before the next rise.
  task automatic strobe_xfer(input logic [3:0] d, input logic [1:0] op);
    bus_if.io_in = {1'b0, 1'b1, op, d};
    repeat (4) @(negedge clk);
    bus_if.io_in[6] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ena      = 1'b1;
    bus_if.io_in  = 8'h00;
    bus_if.uio_in = 8'h00;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset io_out", bus_if.io_out, 8'h00);
    check("reset uio_out", bus_if.uio_out, 8'h01);
    check("reset uio_oe", bus_if.uio_oe, 8'h0F);

    // Add with carry: 9 + 8 = 17 -> result 1, carry 1, with exact latency checks.
    strobe_xfer(4'h9, 2'b00);
    check("after A in LOAD_B", bus_if.uio_out, 8'h02);
    check("busy in LOAD_B", bus_if.io_out, 8'h80);
    bus_if.io_in = {1'b0, 1'b1, 2'b00, 4'h8};
    repeat (3) @(negedge clk);
    check("EXEC state", bus_if.uio_out, 8'h04);
    check("EXEC io_out", bus_if.io_out, 8'h80);
    @(negedge clk);
    check("add 9+8 io_out", bus_if.io_out, 8'h51);
    check("add SHOW state", bus_if.uio_out, 8'h08);
    bus_if.io_in[6] = 1'b0;
    repeat (3) @(negedge clk);

    // Subtract with borrow: 3 - 5 = E, borrow 1.
    strobe_xfer(4'h3, 2'b00);
    check("SHOW strobe drops valid", bus_if.io_out, 8'h91);
    check("SHOW strobe to LOAD_B", bus_if.uio_out, 8'h02);
    strobe_xfer(4'h5, 2'b01);
    check("sub 3-5", bus_if.io_out, 8'h5E);

    // 7 - 7 = 0: zero set, no borrow.
    strobe_xfer(4'h7, 2'b00);
    strobe_xfer(4'h7, 2'b01);
    check("sub 7-7", bus_if.io_out, 8'h60);

    // Logic ops on C and A.
    strobe_xfer(4'hC, 2'b00);
    strobe_xfer(4'hA, 2'b10);
    check("and C&A", bus_if.io_out, 8'h48);
    strobe_xfer(4'hC, 2'b00);
    strobe_xfer(4'hA, 2'b11);
    check("or C|A", bus_if.io_out, 8'h4E);

    // Back-to-back from SHOW: A = 2 then B = 2 -> 4.
    strobe_xfer(4'h2, 2'b00);
    check("b2b valid dropped", bus_if.io_out, 8'h8E);
    check("b2b LOAD_B", bus_if.uio_out, 8'h02);
    strobe_xfer(4'h2, 2'b00);
    check("b2b add 2+2", bus_if.io_out, 8'h44);

    // Stretched strobe: held 20 cycles must capture only A = 5.
    bus_if.io_in = {1'b0, 1'b1, 2'b00, 4'h5};
    repeat (20) @(negedge clk);
    check("stretched one capture", bus_if.uio_out, 8'h02);
    bus_if.io_in[6] = 1'b0;
    repeat (3) @(negedge clk);
    check("stretched after release", bus_if.uio_out, 8'h02);
    strobe_xfer(4'h1, 2'b00);
    check("stretched add 5+1", bus_if.io_out, 8'h46);

    // Clear in LOAD_B: takes effect on the 3rd edge, result held, valid low.
    strobe_xfer(4'h1, 2'b00);
    check("pre-clear LOAD_B", bus_if.io_out, 8'h86);
    bus_if.io_in[7] = 1'b1;
    repeat (2) @(negedge clk);
    check("clear 2 edges still LOAD_B", bus_if.uio_out, 8'h02);
    @(negedge clk);
    check("clear to LOAD_A", bus_if.uio_out, 8'h01);
    check("clear io_out holds result", bus_if.io_out, 8'h06);
    bus_if.io_in[7] = 1'b0;
    repeat (3) @(negedge clk);

    // ena low across an entire strobe pulse: edge is lost.
    ena = 1'b0;
    bus_if.io_in = {1'b0, 1'b1, 2'b00, 4'h9};
    repeat (4) @(negedge clk);
    check("ena low holds state", bus_if.uio_out, 8'h01);
    bus_if.io_in[6] = 1'b0;
    repeat (4) @(negedge clk);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    check("ena low strobe lost", bus_if.uio_out, 8'h01);
    check("ena low io_out", bus_if.io_out, 8'h06);

    // Reset in SHOW with result E.
    strobe_xfer(4'hC, 2'b00);
    strobe_xfer(4'hA, 2'b11);
    check("pre-reset SHOW", bus_if.io_out, 8'h4E);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid reset io_out", bus_if.io_out, 8'h00);
    check("mid reset uio_out", bus_if.uio_out, 8'h01);
    check("mid reset uio_oe", bus_if.uio_oe, 8'h0F);

    // Fresh transaction after reset: 2 + 3 = 5.
    strobe_xfer(4'h2, 2'b00);
    strobe_xfer(4'h3, 2'b00);
    check("post reset add 2+3", bus_if.io_out, 8'h45);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
